// File: rtl/mem_pattern_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_pattern_checker_if
// Description : Avalon-MM bus bundle used by the pattern checker. Collects
//               the command signals (address, byteenable, chipselect, write,
//               read, writedata) and the response signals (readdata,
//               waitrequest) into one connection.
//   master modport : command outputs, response inputs (the checker side)
//   slave  modport : command inputs, response outputs (the memory side)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_pattern_checker_if #(
    parameter int ADDR_W = 13
) ();
    logic [ADDR_W-1:0] avm_address;
    logic [3:0]        avm_byteenable;
    logic              avm_chipselect;
    logic              avm_write;
    logic              avm_read;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata;
    logic              avm_waitrequest;

    modport master (
        output avm_address,
        output avm_byteenable,
        output avm_chipselect,
        output avm_write,
        output avm_read,
        output avm_writedata,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_byteenable,
        input  avm_chipselect,
        input  avm_write,
        input  avm_read,
        input  avm_writedata,
        output avm_readdata,
        output avm_waitrequest
    );
endinterface
`default_nettype wire

// File: rtl/mem_pattern_checker.sv
`default_nettype none
// ============================================================================
// Module      : mem_pattern_checker
// Description : Memory pattern tester. On start it writes an incrementing
//               pattern (seed+i) to word_count consecutive words beginning at
//               base_addr (wrapping at DEPTH), then reads every word back and
//               compares it against the pattern. Reports the error count, the
//               address of the first bad word and a pass flag at the end.
//
//   Ports
//     clk            : sole clock, rising edge
//     reset_n        : asynchronous active-low reset
//     start          : single-cycle run request (accepted in IDLE or DONE)
//     abort          : cancels a run, returns to IDLE next cycle
//     base_addr      : first word address, sampled on accepted start
//     word_count     : words to test (clamped to DEPTH), sampled on start
//     seed           : pattern seed, sampled on accepted start
//     avm            : Avalon-MM master (command out, readdata/waitrequest in)
//     busy           : high in WRITE, READ and DRAIN
//     done           : one-cycle pulse on entry to DONE
//     pass           : run finished with zero mismatches
//     err_count      : saturating mismatch count
//     first_err_addr : address of the first mismatching word of the run
// Revision    : 1.0 - initial release
// ============================================================================
module mem_pattern_checker #(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 5120
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       word_count,
    input  logic [31:0]           seed,
    mem_pattern_checker_if.master avm,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [ADDR_W-1:0]     first_err_addr
);

    // Count-width copy of DEPTH, used for the clamp and for wrapping the base.
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_CNT   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   run_base;      // wrapped start address of the run
    logic [31:0]         run_seed;      // pattern value of word 0
    logic [ADDR_W:0]     run_count;     // clamped word count of the run
    logic [ADDR_W:0]     remaining;     // words still to be accepted in this pass
    logic                rd_pending;    // a read was accepted last cycle
    logic [31:0]         exp_data;      // pattern expected for the pending read
    logic [ADDR_W-1:0]   exp_addr;      // address of the pending read

    // ------------------------------------------------------------------
    // Start-time parameter conditioning
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]   start_base;
    logic [ADDR_W:0]     start_count;

    // A base at or above DEPTH is folded back into range with one subtract;
    // the address counter then wraps at LAST_ADDR for the rest of the run.
    assign start_base  = ({1'b0, base_addr} >= DEPTH_CNT)
                       ? (base_addr - DEPTH_CNT[ADDR_W-1:0])
                       : base_addr;
    assign start_count = (word_count > DEPTH_CNT) ? DEPTH_CNT : word_count;

    // ------------------------------------------------------------------
    // Address sequencing and read-back comparison
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]   next_addr;
    logic                accepted;
    logic                mismatch;
    logic [15:0]         err_next;

    assign next_addr = (avm.avm_address == LAST_ADDR) ? '0
                                                      : avm.avm_address + 1'b1;
    assign accepted  = !avm.avm_waitrequest;

    // Read latency is fixed at one cycle: data for the read accepted on the
    // previous edge is on avm_readdata now.
    assign mismatch  = rd_pending && (avm.avm_readdata != exp_data);
    assign err_next  = (mismatch && (err_count != 16'hFFFF))
                     ? err_count + 16'd1
                     : err_count;

    // ------------------------------------------------------------------
    // Control FSM with registered outputs. avm_writedata doubles as the
    // pattern register: it holds seed+i for the word currently on the bus
    // in both the write and the read pass.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            run_base           <= '0;
            run_seed           <= '0;
            run_count          <= '0;
            remaining          <= '0;
            rd_pending         <= 1'b0;
            exp_data           <= '0;
            exp_addr           <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            pass               <= 1'b0;
            err_count          <= '0;
            first_err_addr     <= '0;
            avm.avm_address    <= '0;
            avm.avm_byteenable <= '0;
            avm.avm_chipselect <= 1'b0;
            avm.avm_write      <= 1'b0;
            avm.avm_read       <= 1'b0;
            avm.avm_writedata  <= '0;
        end else if (abort && (state != IDLE)) begin
            // Abort takes priority over everything, including a start in the
            // same cycle. Results are left untouched; mid-run pass is already 0.
            state              <= IDLE;
            busy               <= 1'b0;
            done               <= 1'b0;
            rd_pending         <= 1'b0;
            avm.avm_chipselect <= 1'b0;
            avm.avm_write      <= 1'b0;
            avm.avm_read       <= 1'b0;
            avm.avm_byteenable <= '0;
        end else begin
            done       <= 1'b0;
            rd_pending <= 1'b0;

            if (rd_pending) begin
                err_count <= err_next;
                // err_count of zero identifies the first mismatch of the run;
                // the counter saturates, so it never returns to zero mid-run.
                if (mismatch && (err_count == 16'd0)) begin
                    first_err_addr <= exp_addr;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_count      <= '0;
                        first_err_addr <= '0;
                        if (start_count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state              <= WRITE;
                            busy               <= 1'b1;
                            pass               <= 1'b0;
                            run_base           <= start_base;
                            run_seed           <= seed;
                            run_count          <= start_count;
                            remaining          <= start_count;
                            avm.avm_address    <= start_base;
                            avm.avm_writedata  <= seed;
                            avm.avm_byteenable <= 4'hF;
                            avm.avm_chipselect <= 1'b1;
                            avm.avm_write      <= 1'b1;
                            avm.avm_read       <= 1'b0;
                        end
                    end
                end

                WRITE: begin
                    if (accepted) begin
                        if (remaining == ONE_CNT) begin
                            // Rewind to word 0 for the read-back pass.
                            state             <= READ;
                            remaining         <= run_count;
                            avm.avm_address   <= run_base;
                            avm.avm_writedata <= run_seed;
                            avm.avm_write     <= 1'b0;
                            avm.avm_read      <= 1'b1;
                        end else begin
                            remaining         <= remaining - ONE_CNT;
                            avm.avm_address   <= next_addr;
                            avm.avm_writedata <= avm.avm_writedata + 32'd1;
                        end
                    end
                end

                READ: begin
                    if (accepted) begin
                        rd_pending <= 1'b1;
                        exp_data   <= avm.avm_writedata;
                        exp_addr   <= avm.avm_address;
                        if (remaining == ONE_CNT) begin
                            state              <= DRAIN;
                            avm.avm_chipselect <= 1'b0;
                            avm.avm_read       <= 1'b0;
                            avm.avm_byteenable <= '0;
                        end else begin
                            remaining         <= remaining - ONE_CNT;
                            avm.avm_address   <= next_addr;
                            avm.avm_writedata <= avm.avm_writedata + 32'd1;
                        end
                    end
                end

                DRAIN: begin
                    // The final word is compared on this edge, so pass must
                    // look at the post-compare count.
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_next == 16'd0);
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_pattern_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_pattern_checker
// Description : Self-checking bench for mem_pattern_checker. Holds a word
//               array memory model (one-cycle read latency, optional random
//               waitrequest, optional corruption of one address) and a
//               reference model of the expected run outcome.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_pattern_checker;

    localparam int ADDR_W = 13;
    localparam int DEPTH  = 5120;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic [31:0]       seed;
    logic              busy;
    logic              done;
    logic              pass;
    logic [15:0]       err_count;
    logic [ADDR_W-1:0] first_err_addr;

    always #5 clk = ~clk;

    mem_pattern_checker_if #(.ADDR_W(ADDR_W)) bus ();

    mem_pattern_checker #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .seed           (seed),
        .avm            (bus),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    // ---------------- memory model ----------------
    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic [31:0] mem [DEPTH];
    wr_t         wr_log[$];
    bit          wait_en = 1'b0;
    bit          cor_en  = 1'b0;
    int          cor_addr = 0;
    int          wr_in_reset = 0;

    always @(posedge clk) begin
        if (!reset_n && bus.avm_write) wr_in_reset++;
        if (bus.avm_chipselect && bus.avm_write && !bus.avm_waitrequest) begin
            mem[bus.avm_address] = bus.avm_writedata;
            wr_log.push_back('{int'(bus.avm_address), bus.avm_writedata});
        end
        if (bus.avm_chipselect && bus.avm_read && !bus.avm_waitrequest)
            bus.avm_readdata <= mem[bus.avm_address] ^
                ((cor_en && int'(bus.avm_address) == cor_addr) ? 32'h0000_0100 : 32'h0);
    end

    always @(negedge clk)
        bus.avm_waitrequest = wait_en ? 1'($urandom_range(0, 1)) : 1'b0;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference outcome: walk the words of the run and count those whose
    // address falls on the corrupted location.
    function automatic void model(input int base, input int wc, input bit ce, input int ca,
                                  output int n, output int errs, output int first);
        n     = (wc > DEPTH) ? DEPTH : wc;
        errs  = 0;
        first = 0;
        for (int i = 0; i < n; i++) begin
            int a;
            a = (base + i) % DEPTH;
            if (ce && a == ca) begin
                if (errs == 0) first = a;
                errs++;
            end
        end
    endfunction

    // One complete run: start, optional stray start pulse at cycle `glitch`,
    // wait for done, then check results, write sequence and latency.
    task automatic run(input string tag, input int base, input int wc, input logic [31:0] sd,
                       input bit we, input bit ce, input int ca, input int glitch,
                       input bit e_pass, input int e_err, input int e_first);
        int n, lat, bound, bad, m_err, m_first;
        model(base, wc, ce, ca, n, m_err, m_first);
        wait_en  = we;
        cor_en   = ce;
        cor_addr = ca;
        wr_log.delete();
        @(negedge clk);
        base_addr  = ADDR_W'(base);
        word_count = (ADDR_W+1)'(wc);
        seed       = sd;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        bound = 20 * n + 40;
        while (!done && lat < bound) begin
            if (lat == glitch) begin
                start      = 1'b1;
                base_addr  = 13'd77;
                word_count = 14'd3;
                seed       = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, " done"}, 64'(done), 64'd1);
        if (!we) check({tag, " latency"}, 64'(lat), (n == 0) ? 64'd0 : 64'(2 * n + 1));
        check({tag, " pass"}, 64'(pass), 64'(e_pass));
        check({tag, " err_count"}, 64'(err_count), 64'(e_err));
        check({tag, " first_err_addr"}, 64'(first_err_addr), 64'(e_first));
        check({tag, " idle strobes"}, 64'({busy, bus.avm_chipselect, bus.avm_write, bus.avm_read}), 64'd0);
        check({tag, " write count"}, 64'(wr_log.size()), 64'(n));
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= wr_log.size()) bad++;
            else if (wr_log[i].addr != (base + i) % DEPTH || wr_log[i].data !== sd + 32'(i)) bad++;
        end
        check({tag, " write sequence errors"}, 64'(bad), 64'd0);
        @(negedge clk);
        check({tag, " done one cycle"}, 64'(done), 64'd0);
        check({tag, " pass held"}, 64'(pass), 64'(e_pass));
        wait_en = 1'b0;
        cor_en  = 1'b0;
    endtask

    typedef struct {
        string       tag;
        int          base;
        int          wc;
        logic [31:0] sd;
        bit          we;
        bit          ce;
        int          ca;
        int          glitch;
        bit          e_pass;
        int          e_err;
        int          e_first;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int seen, n, m_err, m_first, rb, rwc, rca;
        bit rwe, rce;
        logic [31:0] rsd;

        vecs[0] = '{"basic16",    0,    16,   32'h1000_0000, 0, 0, 0,    -1, 1, 0, 0};
        vecs[1] = '{"corrupt5",   0,    16,   32'h1000_0000, 0, 1, 5,    -1, 0, 1, 5};
        vecs[2] = '{"zero words", 0,    0,    32'h0000_1234, 0, 0, 0,    -1, 1, 0, 0};
        vecs[3] = '{"wrap",       5118, 4,    32'hABCD_0000, 0, 0, 0,    -1, 1, 0, 0};
        vecs[4] = '{"waitreq",    0,    16,   32'h1000_0000, 1, 0, 0,    -1, 1, 0, 0};
        vecs[5] = '{"single bad", 100,  1,    32'h0000_0055, 0, 1, 100,  -1, 0, 1, 100};
        vecs[6] = '{"clamp",      3000, 6000, 32'hFFFF_FFF0, 0, 1, 2000, -1, 0, 1, 2000};
        vecs[7] = '{"start in write", 0, 16,  32'h1000_0000, 0, 0, 0,    5,  1, 0, 0};
        vecs[8] = '{"start in read",  0, 16,  32'h2000_0000, 0, 0, 0,    20, 1, 0, 0};

        reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        seed       = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", 64'({busy, done, pass, err_count, first_err_addr}), 64'd0);
        check("reset bus", 64'({bus.avm_chipselect, bus.avm_write, bus.avm_read,
                                bus.avm_byteenable, bus.avm_address}), 64'd0);
        reset_n = 1'b1;

        // ---- table-driven runs ----
        for (int v = 0; v < 9; v++)
            run(vecs[v].tag, vecs[v].base, vecs[v].wc, vecs[v].sd, vecs[v].we, vecs[v].ce,
                vecs[v].ca, vecs[v].glitch, vecs[v].e_pass, vecs[v].e_err, vecs[v].e_first);

        // ---- randomized runs against the reference model ----
        for (int r = 0; r < 6; r++) begin
            rb  = int'($urandom_range(0, DEPTH - 1));
            rwc = int'($urandom_range(0, 40));
            rsd = $urandom;
            rwe = 1'($urandom_range(0, 1));
            rce = 1'($urandom_range(0, 1));
            rca = (rb + int'($urandom_range(0, 60))) % DEPTH;
            model(rb, rwc, rce, rca, n, m_err, m_first);
            run($sformatf("random%0d", r), rb, rwc, rsd, rwe, rce, rca, -1,
                m_err == 0, m_err, m_first);
        end

        // ---- abort together with start while in DONE: abort wins ----
        @(negedge clk);
        word_count = 14'd16;
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort+start busy", 64'({busy, bus.avm_chipselect, done}), 64'd0);
        @(negedge clk);
        check("abort+start stays idle", 64'({busy, bus.avm_chipselect}), 64'd0);

        // ---- abort during the 8th write ----
        wr_log.delete();
        base_addr  = '0;
        word_count = 14'd16;
        seed       = 32'h1000_0000;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("abort pre writes", 64'(wr_log.size()), 64'd7);
        check("abort pre address", 64'(bus.avm_address), 64'd7);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort strobes", 64'({busy, done, bus.avm_chipselect, bus.avm_write, bus.avm_read}), 64'd0);
        check("abort pass", 64'(pass), 64'd0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy || bus.avm_chipselect) seen++;
        end
        check("abort quiet", 64'(seen), 64'd0);

        // ---- reset asserted during READ ----
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("pre-reset in read", 64'({bus.avm_read, bus.avm_write}), 64'b10);
        #2 reset_n = 1'b0;
        #1;
        check("async reset outputs", 64'({busy, done, pass, err_count, first_err_addr}), 64'd0);
        check("async reset bus", 64'({bus.avm_chipselect, bus.avm_write, bus.avm_read,
                                      bus.avm_byteenable, bus.avm_address}), 64'd0);
        check("async reset writedata", 64'(bus.avm_writedata), 64'd0);
        wr_in_reset = 0;
        repeat (3) @(negedge clk);
        check("writes during reset", 64'(wr_in_reset), 64'd0);
        reset_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("run discarded by reset", 64'(seen), 64'd0);
        run("zero after reset", 0, 0, 32'h0, 0, 0, 0, -1, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
